// File: rtl/pmem_adapter_pkg.sv
// pmem_adapter_pkg: shared state encoding and default geometry for the line adapter
package pmem_adapter_pkg;
  typedef enum logic [1:0] {IDLE, BEAT, BACKOFF, DONE} state_t;
  localparam int BEATS = 4;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int WORD_BYTES = 4;
  localparam int LINE_OFFSET_BITS = $clog2(BEATS * WORD_BYTES);
endpackage

// File: rtl/pmem_line_buffer.sv
// pmem_line_buffer: word-addressable line register with parallel load and flat view
module pmem_line_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int BEATS = 4,
  parameter int IDX_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [BEATS*WORD_WIDTH-1:0] load_line,
  input  logic                        store,
  input  logic [IDX_BITS-1:0]         idx,
  input  logic [WORD_WIDTH-1:0]       store_word,
  output logic [WORD_WIDTH-1:0]       word,
  output logic [BEATS*WORD_WIDTH-1:0] line
);
  logic [WORD_WIDTH-1:0] words [BEATS];
  // whole-line load wins over a single-word store
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < BEATS; i++) words[i] <= '0;
    else if (load)
      for (int i = 0; i < BEATS; i++) words[i] <= load_line[i*WORD_WIDTH +: WORD_WIDTH];
    else if (store)
      words[idx] <= store_word;
  assign word = words[idx];
  for (genvar g = 0; g < BEATS; g++) begin : g_flat
    assign line[g*WORD_WIDTH +: WORD_WIDTH] = words[g];
  end
endmodule

// File: rtl/pmem_line_adapter.sv
// pmem_line_adapter: splits one line-wide cache transaction into word beats on the memory bus
module pmem_line_adapter
  import pmem_adapter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = WORD_BYTES * 8,
  parameter int LINE_WIDTH = BEATS * WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cache_action_stb,
  input  logic                  cache_action_cyc,
  input  logic                  cache_write,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic [LINE_WIDTH-1:0] cache_wdata,
  output logic [LINE_WIDTH-1:0] cache_rdata,
  output logic                  cache_resp,
  output logic                  cache_retry,
  output logic                  mem_action_stb,
  output logic                  mem_action_cyc,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  input  logic                  mem_retry
);
  localparam int nbeats = LINE_WIDTH / WORD_WIDTH;
  localparam int bits = $clog2(nbeats);
  localparam int word_off = $clog2(WORD_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] off_mask = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  state_t state, state_n;
  logic [bits-1:0] beat;
  logic [ADDR_WIDTH-1:0] base;
  logic wr, req, accept, beat_done, last;
  logic [LINE_WIDTH-1:0] line, fill_line;
  logic [WORD_WIDTH-1:0] word;
  assign req = cache_action_stb & cache_action_cyc;
  assign accept = (state == IDLE) & req;
  assign beat_done = (state == BEAT) & mem_resp;
  assign last = &beat;
  assign cache_retry = rst_n & req & ~cache_resp;
  assign mem_write = mem_action_stb & wr;
  assign mem_addr = mem_action_stb ? base + (ADDR_WIDTH'(beat) << word_off) : '0;
  assign mem_wdata = mem_action_stb ? word : '0;
  pmem_line_buffer #(.WORD_WIDTH(WORD_WIDTH), .BEATS(nbeats), .IDX_BITS(bits)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .load_line(cache_wdata),
    .store(beat_done & ~wr),
    .idx(beat),
    .store_word(mem_rdata),
    .word(word),
    .line(line)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state and bus control; a response outranks a simultaneous retry
  always_comb begin
    state_n = state;
    mem_action_stb = 1'b0;
    mem_action_cyc = 1'b0;
    cache_resp = 1'b0;
    case (state)
      IDLE: state_n = req ? BEAT : IDLE;
      BEAT: begin
        mem_action_stb = 1'b1;
        mem_action_cyc = 1'b1;
        state_n = mem_resp ? (last ? DONE : BEAT) : (mem_retry ? BACKOFF : BEAT);
      end
      BACKOFF: begin
        mem_action_cyc = 1'b1;
        state_n = BEAT;
      end
      default: begin
        cache_resp = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  // the last fill word bypasses the buffer so cache_rdata is complete while cache_resp is high
  always_comb begin
    fill_line = line;
    fill_line[beat*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
  end
  // request latch, beat counter (wraps to 0 after the last beat) and filled-line register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      wr <= 1'b0;
      beat <= '0;
      cache_rdata <= '0;
    end else begin
      if (accept) begin
        base <= cache_addr & ~off_mask;
        wr <= cache_write;
        beat <= '0;
      end
      if (beat_done) beat <= beat + 1'b1;
      if (beat_done && last && !wr) cache_rdata <= fill_line;
    end
endmodule

// File: tb/tb_pmem_line_adapter.sv
// tb_pmem_line_adapter: randomized memory responder checked against a transaction-level model
module tb_pmem_line_adapter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cache_action_stb = 1'b0, cache_action_cyc = 1'b0, cache_write = 1'b0;
  logic [31:0] cache_addr = '0;
  logic [127:0] cache_wdata = '0, cache_rdata;
  logic cache_resp, cache_retry, mem_action_stb, mem_action_cyc, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic mem_resp = 1'b0, mem_retry = 1'b0;
  int checks = 0, failures = 0;
  int pw[4];
  bit pr[4], pb[4];
  bit seq_data = 1'b0, prev_hold = 1'b0, hold_now;
  logic [127:0] last_fill = '0;

  pmem_line_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .cache_action_stb(cache_action_stb), .cache_action_cyc(cache_action_cyc),
    .cache_write(cache_write), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_resp(cache_resp), .cache_retry(cache_retry),
    .mem_action_stb(mem_action_stb), .mem_action_cyc(mem_action_cyc),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_retry(mem_retry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic plan(input int maxw, input int rpct);
    for (int i = 0; i < 4; i++) begin
      pw[i] = $urandom_range(0, maxw);
      pr[i] = $urandom_range(0, 99) < rpct;
      pb[i] = $urandom_range(0, 3) == 0;
    end
  endtask

  task automatic plan_fixed(input int w);
    for (int i = 0; i < 4; i++) begin
      pw[i] = w;
      pr[i] = 1'b0;
      pb[i] = 1'b0;
    end
  endtask

  // one cache transaction: the cycle cache_resp is due follows from the per-beat plan
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [127:0] d,
                         input bit hold, input int extra, input bit drop);
    int k = 0, n = 0, wl, exp_cyc;
    bit rl, cs, cc;
    logic [31:0] base;
    logic [127:0] got_line = '0;
    base = a & ~32'hF;
    exp_cyc = 1 + extra;
    for (int i = 0; i < 4; i++) exp_cyc += pw[i] + 1 + 2 * int'(pr[i]);
    wl = pw[0];
    rl = pr[0];
    cache_action_stb = 1'b1;
    cache_action_cyc = 1'b1;
    cache_write = w;
    cache_addr = a;
    cache_wdata = d;
    while (n < exp_cyc) begin
      @(negedge clk);
      n++;
      cs = cache_action_stb;
      cc = cache_action_cyc;
      chk("cache_resp", cache_resp, n == exp_cyc);
      chk("cache_retry", cache_retry, cs & cc & (n != exp_cyc));
      chk("mem_cyc", mem_action_cyc, n >= 1 + extra && n < exp_cyc);
      if (n < exp_cyc) chk("rdata_hold", cache_rdata, last_fill);
      if (mem_action_stb && k > 3) chk("extra_beat", k, 3);
      else if (mem_action_stb) begin
        chk("mem_addr", mem_addr, base + 32'(k * 4));
        chk("mem_write", mem_write, w);
        if (w) chk("mem_wdata", mem_wdata, d[k*32 +: 32]);
        if (wl > 0) begin
          mem_resp = 1'b0;
          mem_retry = 1'b0;
          wl--;
        end else if (rl) begin
          mem_resp = 1'b0;
          mem_retry = 1'b1;
          rl = 1'b0;
        end else begin
          mem_resp = 1'b1;
          mem_retry = pb[k];
          mem_rdata = seq_data ? 32'hA0 + 32'(k) : $urandom;
          got_line[k*32 +: 32] = mem_rdata;
          k++;
          if (k < 4) begin
            wl = pw[k];
            rl = pr[k];
          end
        end
      end else begin
        mem_resp = 1'($urandom_range(0, 1));
        mem_retry = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (drop && n == 2) cache_action_cyc = 1'b0;
    end
    chk("beats", k, 4);
    if (!w) last_fill = got_line;
    chk("rdata", cache_rdata, last_fill);
    mem_resp = 1'b0;
    mem_retry = 1'b0;
    if (!hold) begin
      cache_action_stb = 1'b0;
      cache_action_cyc = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stb", mem_action_stb, 0);
    chk("rst_cyc", mem_action_cyc, 0);
    chk("rst_resp", cache_resp, 0);
    chk("rst_retry", cache_retry, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", cache_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    seq_data = 1'b1;
    plan_fixed(0);
    run_txn(1'b0, 32'h0000_1234, 128'h0, 1'b0, 0, 1'b0);
    chk("fill_const", cache_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
    seq_data = 1'b0;
    run_txn(1'b1, 32'h0000_2000, 128'h44444444_33333333_22222222_11111111, 1'b0, 0, 1'b0);
    plan_fixed(0);
    pr[2] = 1'b1;
    pb[1] = 1'b1;
    run_txn(1'b0, 32'h0000_3008, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1'b0);
    plan_fixed(2);
    run_txn(1'b0, 32'h0000_40F0, 128'h0, 1'b0, 0, 1'b0);
    cache_action_stb = 1'b1;
    cache_action_cyc = 1'b1;
    cache_write = 1'b0;
    cache_addr = 32'h0000_5678;
    @(negedge clk);
    chk("mid_stb", mem_action_stb, 1);
    chk("mid_addr0", mem_addr, 32'h5670);
    mem_resp = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    chk("mid_addr1", mem_addr, 32'h5674);
    mem_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_stb", mem_action_stb, 0);
    chk("arst_cyc", mem_action_cyc, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_resp", cache_resp, 0);
    chk("arst_retry", cache_retry, 0);
    chk("arst_rdata", cache_rdata, 0);
    last_fill = '0;
    cache_action_stb = 1'b0;
    cache_action_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    plan_fixed(0);
    run_txn(1'b0, 32'h0000_6004, 128'h0, 1'b0, 0, 1'b0);
    plan(2, 30);
    run_txn(1'b0, 32'h0000_7000, 128'h0, 1'b1, 0, 1'b0);
    plan(2, 30);
    run_txn(1'b0, 32'h0000_8010, 128'h0, 1'b0, 1, 1'b0);
    plan(2, 30);
    run_txn(1'b0, 32'h0000_9020, 128'h0, 1'b0, 0, 1'b1);
    for (int t = 0; t < 40; t++) begin
      plan(3, 30);
      hold_now = $urandom_range(0, 3) == 0;
      run_txn(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom},
              hold_now, int'(prev_hold), 1'b0);
      prev_hold = hold_now;
    end
    if (prev_hold) begin
      cache_action_stb = 1'b0;
      cache_action_cyc = 1'b0;
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
